nibble_serial_add_sub_ctrl: RTL
===============================

Name: nibble_serial_add_sub_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit adder/subtractor slice, one nibble per clock, LSB nibble first. It sits between a requesting datapath and the 4-bit arithmetic slice. It owns the operand latches, the carry chaining between nibbles, result assembly, status flags and the start/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4 derived.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready
sub  input  1  0 = A+B, 1 = A-B; sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
ready  output  1  high in IDLE and DONE; a new start is accepted
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  sum/difference; held until the next accepted start
cout  output  1  final carry out (for sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow
zero  output  1  result == 0

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset, asynchronous on rst_n low: state = IDLE, nibble index = 0, result = 0, cout/overflow/zero/done/busy = 0, ready = 1. Reset during RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches op_a, op_b and sub.
  - Sets idx = 0 and carry = sub. The B-inversion plus carry-in of 1 forms the two's complement.
  - Clears result, then goes to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - Computes nibble idx = A[4i+3:4i] + (B[4i+3:4i] XOR {4{sub}}) + carry.
  - Writes the 4-bit sum into result[4i+3:4i] and stores the nibble carry-out in carry.
  - Increments idx.
  - On the edge that processes idx = NIB-1, goes to DONE.
  - start is ignored in RUN: no queueing and no error.
- DONE, one cycle:
  - done = 1.
  - cout = final carry.
  - overflow = (A[W-1] == Beff[W-1]) && (result[W-1] != A[W-1]), where Beff = B XOR {W{sub}}.
  - zero = (result == 0).
  - Next edge: start=1 accepts a new operation back-to-back (latch, go to RUN); otherwise go to IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+NIB. Throughput is one operation per NIB+1 cycles.
- Flags and result remain stable from DONE until the next accepted start.
  - cout, overflow and zero are cleared when a start is accepted.
  - result is cleared when a start is accepted and filled nibble by nibble during RUN.
- Wrap-around: results are modulo 2^WIDTH. An unsigned overflow shows only on cout; a signed overflow shows only on overflow.
- WIDTH = 4 degenerates to a single RUN cycle.
- Operand inputs may change freely after the accepting edge.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_DONE) and the nibble width constant NIB_W = 4.
- One sub-module, nibble_add_sub: a 4-bit combinational slice with inputs a[3:0], b[3:0], sub, cin and outputs s[3:0], cout.
  - It has an explicit carry-in separate from sub so that carry chaining between nibbles works.
  - The controller instantiates it once and muxes the nibbles in by idx.

Test Plan:
- Reset: hold rst_n low, then release → ready=1, busy=0, done=0, result=0x0000. Assert rst_n low mid-RUN → immediate IDLE and no done pulse.
- Add with ripple: A=0x0FFF, B=0x0001, sub=0 → done exactly 4 cycles after the accept edge; result=0x1000, cout=0, overflow=0, zero=0.
- Subtract to zero: A=0x1234, B=0x1234, sub=1 → result=0x0000, cout=1, zero=1, overflow=0.
- Borrow and signed overflow:
  - A=0x8000, B=0x0001, sub=1 → result=0x7FFF, cout=1, overflow=1.
  - A=0x0000, B=0x0001, sub=1 → result=0xFFFF, cout=0, overflow=0.
- Unsigned wrap: A=0xFFFF, B=0x0001, sub=0 → result=0x0000, cout=1, zero=1, overflow=0.
- Handshake:
  - Pulse start during RUN → ignored; the first result is unchanged.
  - Hold start high during DONE with A=0x0002, B=0x0003 → new op accepted back-to-back; next done shows result=0x0005.

Source files
------------

// File: rtl/nibble_serial_add_sub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// state encoding and the width of the arithmetic slice.
package nibble_serial_add_sub_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add_sub.sv
// 4-bit combinational add/subtract slice. Carry-in is separate from sub so the
// sequencer can chain carries between nibbles.
module nibble_add_sub
  import nibble_serial_add_sub_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b ^ {NIB_W{sub}}} + {{NIB_W{1'b0}}, cin};
  assign s    = sum[NIB_W-1:0];
  assign cout = sum[NIB_W];

endmodule

// File: rtl/nibble_serial_add_sub_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit slice, LSB nibble first.
// Result, flags and handshake outputs are all registered.
module nibble_serial_add_sub_ctrl
  import nibble_serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output state_e           state_dbg
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshake: start is taken on any rising edge where ready is high (IDLE or
  // DONE); operands and sub are latched on that same edge and may change
  // afterwards. start is ignored while busy. done pulses for exactly one cycle
  // and result/flags then hold until the next accepted start.
  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sub_q;
  logic               carry_q;
  logic [WIDTH-1:0]   result_q;
  logic               cout_q, ovf_q, zero_q;
  logic               done_q, busy_q, ready_q;

  logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
  logic               nib_cout;
  logic [WIDTH-1:0]   result_d;
  logic               last_nib;
  logic               ovf_d;

  assign nib_a = a_q[{idx_q, 2'b00} +: NIB_W];
  assign nib_b = b_q[{idx_q, 2'b00} +: NIB_W];

  nibble_add_sub u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

  always_comb begin
    result_d = result_q;
    result_d[{idx_q, 2'b00} +: NIB_W] = nib_s;
  end

  assign last_nib = (idx_q == IDX_W'(NIB - 1));
  // Signed overflow: both effective operands share a sign the result lacks.
  assign ovf_d    = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                    (result_d[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            sub_q    <= sub;
            carry_q  <= sub;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= ST_RUN;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          carry_q  <= nib_cout;
          idx_q    <= idx_q + IDX_W'(1);
          if (last_nib) begin
            cout_q  <= nib_cout;
            ovf_q   <= ovf_d;
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign state_dbg = state_q;

endmodule
